// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant, a 2-bit winner index
// and an optional per-tenure hold limit. Every tenure is followed by one idle cycle.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic [0:0] state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [7:0] req_twice;
  logic [3:0] req_rot;
  logic [1:0] offset;
  logic [1:0] winner;
  logic       any_req;
  logic       release_now;

  // Same decode as the 2-to-4 select decoder: index {a1,a0} -> one-hot line.
  function automatic logic [3:0] decode_2to4(input logic [1:0] sel);
    logic [3:0] line;
    line = 4'b0000;
    line[sel] = 1'b1;
    return line;
  endfunction

  // Rotate so that bit 0 is the requester at ptr; the first set bit is the winner's distance.
  always_comb begin
    req_twice = {req, req};
    req_rot   = req_twice[ptr +: 4];
    any_req   = |req;
    if (req_rot[0])      offset = 2'd0;
    else if (req_rot[1]) offset = 2'd1;
    else if (req_rot[2]) offset = 2'd2;
    else                 offset = 2'd3;
    winner = ptr + offset;
  end

  always_comb begin
    release_now = !req[gnt_id];
    if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT)) release_now = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt      <= 4'b0000;
      gnt_id   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= GRANT;
            gnt      <= decode_2to4(winner);
            gnt_id   <= winner;
            hold_cnt <= 8'd1;
          end
        end
        GRANT: begin
          // gnt_id is left alone on release so it keeps naming the last owner.
          if (release_now) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            ptr      <= gnt_id + 2'd1;
            hold_cnt <= 8'd0;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: one instance with MAX_HOLD=8 (a) and one with MAX_HOLD=0 (b)
// share clock, reset and requests; directed scenarios plus a random run against a model.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_id_a, gnt_id_b;
  logic       gnt_valid_a, gnt_valid_b;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter4 #(.MAX_HOLD(8)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a), .gnt_id(gnt_id_a), .gnt_valid(gnt_valid_a)
  );

  rr_arbiter4 #(.MAX_HOLD(0)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_b), .gnt_id(gnt_id_b), .gnt_valid(gnt_valid_b)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // Reference model: who owns the resource, for how long, and where the search starts.
  int m_busy[2];
  int m_id[2];
  int m_ptr[2];
  int m_len[2];
  int m_limit[2] = '{8, 0};

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt(input int m);
    logic [3:0] v;
    v = 4'b0000;
    if (m_busy[m] != 0) v[m_id[m]] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_busy[m] <= 0;
        m_id[m]   <= 0;
        m_ptr[m]  <= 0;
        m_len[m]  <= 0;
      end else if (m_busy[m] == 0) begin
        if (pick(m_ptr[m], req) >= 0) begin
          m_busy[m] <= 1;
          m_id[m]   <= pick(m_ptr[m], req);
          m_len[m]  <= 1;
        end
      end else if (req[m_id[m]] == 1'b0 || (m_limit[m] != 0 && m_len[m] == m_limit[m])) begin
        m_busy[m] <= 0;
        m_ptr[m]  <= (m_id[m] + 1) % 4;
        m_len[m]  <= 0;
      end else begin
        m_len[m] <= (m_len[m] >= 255) ? 255 : m_len[m] + 1;
      end
    end
  end

  // driver tasks: inputs change just after the falling edge, outputs sampled there too
  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt_a !== 4'b0000 || gnt_valid_a !== 1'b0 || gnt_id_a !== 2'd0) begin
        n_bad++;
        $display("FAIL reset_a: gnt=%b valid=%b id=%0d, expected 0000/0/0", gnt_a, gnt_valid_a, gnt_id_a);
      end
      n_cmp++;
      if (gnt_b !== 4'b0000 || gnt_valid_b !== 1'b0 || gnt_id_b !== 2'd0) begin
        n_bad++;
        $display("FAIL reset_b: gnt=%b valid=%b id=%0d, expected 0000/0/0", gnt_b, gnt_valid_b, gnt_id_b);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0001 || gnt_id_a !== 2'd0 || gnt_valid_a !== 1'b1) begin
      n_bad++;
      $display("FAIL first_grant: gnt=%b id=%0d valid=%b, expected 0001/0/1", gnt_a, gnt_id_a, gnt_valid_a);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt_a !== 4'b0100 || gnt_id_a !== 2'd2) begin
        n_bad++;
        $display("FAIL single_hold[%0d]: gnt=%b id=%0d, expected 0100/2", i, gnt_a, gnt_id_a);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0000 || gnt_valid_a !== 1'b0 || gnt_id_a !== 2'd2) begin
      n_bad++;
      $display("FAIL single_release: gnt=%b valid=%b id=%0d, expected 0000/0/2", gnt_a, gnt_valid_a, gnt_id_a);
    end
    req = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b1000 || gnt_id_a !== 2'd3) begin
      n_bad++;
      $display("FAIL single_next_ptr: gnt=%b id=%0d, expected 1000/3", gnt_a, gnt_id_a);
    end
  endtask

  task automatic test_rotation();
    int ids[$];
    int lens[$];
    int gaps[$];
    int cur_len;
    int cur_id;
    int gap_len;
    do_reset();
    cur_len = 0;
    cur_id  = 0;
    gap_len = 0;
    req = 4'b1111;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      n_cmp++;
      if ($countones(gnt_a) > 1 || gnt_valid_a !== (|gnt_a) ||
          (gnt_valid_a && gnt_a !== (4'b0001 << gnt_id_a))) begin
        n_bad++;
        $display("FAIL rot_invariant[%0d]: gnt=%b valid=%b id=%0d", i, gnt_a, gnt_valid_a, gnt_id_a);
      end
      if (gnt_valid_a) begin
        if (cur_len > 0 && int'(gnt_id_a) != cur_id) begin
          ids.push_back(cur_id);
          lens.push_back(cur_len);
          gaps.push_back(0);
          cur_len = 0;
        end else if (cur_len == 0 && ids.size() > 0) begin
          gaps.push_back(gap_len);
        end
        if (cur_len == 0) cur_id = int'(gnt_id_a);
        cur_len++;
        gap_len = 0;
      end else begin
        if (cur_len > 0) begin
          ids.push_back(cur_id);
          lens.push_back(cur_len);
        end
        cur_len = 0;
        gap_len++;
      end
    end
    req = 4'b0000;
    n_cmp++;
    if (ids.size() < 5 || gaps.size() < 4) begin
      n_bad++;
      $display("FAIL rot_count: tenures=%0d gaps=%0d, expected at least 5/4", ids.size(), gaps.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (ids[k] != k % 4 || lens[k] != 8) begin
          n_bad++;
          $display("FAIL rot_tenure[%0d]: id=%0d len=%0d, expected %0d/8", k, ids[k], lens[k], k % 4);
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (gaps[k] != 1) begin
          n_bad++;
          $display("FAIL rot_gap[%0d]: gap=%0d, expected 1", k, gaps[k]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0011;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0001 || gnt_id_a !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap_from_2: gnt=%b id=%0d, expected 0001/0", gnt_a, gnt_id_a);
    end
    req = 4'b0000;
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b1000 || gnt_id_a !== 2'd3) begin
      n_bad++;
      $display("FAIL wrap_owner3: gnt=%b id=%0d, expected 1000/3", gnt_a, gnt_id_a);
    end
    req = 4'b1001;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt_a !== 4'b1000) begin
        n_bad++;
        $display("FAIL wrap_hold[%0d]: gnt=%b, expected 1000", i, gnt_a);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0000) begin
      n_bad++;
      $display("FAIL wrap_forced_release: gnt=%b, expected 0000", gnt_a);
    end
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0001 || gnt_id_a !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap_after_3: gnt=%b id=%0d, expected 0001/0", gnt_a, gnt_id_a);
    end
  endtask

  task automatic test_hog();
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt_a !== ((i % 9 == 8) ? 4'b0000 : 4'b0001)) begin
        n_bad++;
        $display("FAIL hog_limited[%0d]: gnt=%b, expected %b", i, gnt_a, (i % 9 == 8) ? 4'b0000 : 4'b0001);
      end
      n_cmp++;
      if (gnt_b !== 4'b0001) begin
        n_bad++;
        $display("FAIL hog_unlimited[%0d]: gnt=%b, expected 0001", i, gnt_b);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (gnt_b !== 4'b0000 || gnt_valid_b !== 1'b0) begin
      n_bad++;
      $display("FAIL hog_unlimited_drop: gnt=%b valid=%b, expected 0000/0", gnt_b, gnt_valid_b);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_setup: gnt=%b, expected 1000", gnt_a);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0000 || gnt_valid_a !== 1'b0 || gnt_id_a !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_reset: gnt=%b valid=%b id=%0d, expected 0000/0/0", gnt_a, gnt_valid_a, gnt_id_a);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0010 || gnt_id_a !== 2'd1) begin
      n_bad++;
      $display("FAIL mid_regrant: gnt=%b id=%0d, expected 0010/1", gnt_a, gnt_id_a);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = 4'b0000;
      rst = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      n_cmp++;
      if (gnt_a !== exp_gnt(0) || gnt_id_a !== 2'(m_id[0]) || gnt_valid_a !== (m_busy[0] != 0)) begin
        n_bad++;
        $display("FAIL rand_a[%0d]: gnt=%b id=%0d valid=%b, expected %b/%0d/%0d",
                 i, gnt_a, gnt_id_a, gnt_valid_a, exp_gnt(0), m_id[0], m_busy[0]);
      end
      n_cmp++;
      if (gnt_b !== exp_gnt(1) || gnt_id_b !== 2'(m_id[1]) || gnt_valid_b !== (m_busy[1] != 0)) begin
        n_bad++;
        $display("FAIL rand_b[%0d]: gnt=%b id=%0d valid=%b, expected %b/%0d/%0d",
                 i, gnt_b, gnt_id_b, gnt_valid_b, exp_gnt(1), m_id[1], m_busy[1]);
      end
    end
    rst = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_hog();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
